// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: a $4014 write halts the CPU and streams XFER_LEN bytes
// from page {reg_wdata, 00} to OAMDATA as alternating get/put bus cycles.
module oam_dma_controller #(
  parameter logic [15:0] OAMDATA_ADDR = 16'h2004,
  // Power of two, at most 256; idx is a fixed 8-bit byte index.
  parameter int unsigned XFER_LEN     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic        reg_we,
  input  logic [7:0]  reg_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        cpu_rdy,
  output logic        dma_bus_own,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  output logic        dma_wr,
  output logic [7:0]  dma_wdata,
  output logic        dma_busy,
  output logic        put_cycle
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t     state_q, state_d;
  logic       put_q, put_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      put_q   <= 1'b0;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      put_q   <= put_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // Everything advances on CPU cycle boundaries only; parity runs free.
  always_comb begin
    state_d = state_q;
    put_d   = put_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    if (cpu_ce) begin
      put_d = ~put_q;
      case (state_q)
        S_IDLE: begin
          if (reg_we) begin
            page_d  = reg_wdata;
            idx_d   = 8'h00;
            state_d = S_HALT;
          end
        end
        // A put HALT cycle is followed by a get, so READ can start at once.
        S_HALT:  state_d = put_q ? S_READ : S_ALIGN;
        S_ALIGN: state_d = S_READ;
        S_READ: begin
          data_d  = bus_rdata;
          state_d = S_WRITE;
        end
        S_WRITE: begin
          if (idx_q == LAST_IDX) begin
            idx_d   = 8'h00;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_rdy     = 1'b0;
    dma_bus_own = 1'b0;
    dma_addr    = 16'h0000;
    dma_rd      = 1'b0;
    dma_wr      = 1'b0;
    dma_wdata   = 8'h00;
    dma_busy    = (state_q != S_IDLE);
    put_cycle   = put_q;
    case (state_q)
      S_IDLE:  cpu_rdy = 1'b1;
      S_HALT:  ;
      // Dummy cycle: bus owned, address parked on OAMDATA, no strobe.
      S_ALIGN: begin
        dma_bus_own = 1'b1;
        dma_addr    = OAMDATA_ADDR;
      end
      S_READ: begin
        dma_bus_own = 1'b1;
        dma_rd      = 1'b1;
        dma_addr    = {page_q, idx_q};
      end
      S_WRITE: begin
        dma_bus_own = 1'b1;
        dma_wr      = 1'b1;
        dma_addr    = OAMDATA_ADDR;
        dma_wdata   = data_q;
      end
      default: cpu_rdy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: a cycle-count model of the transfer is compared
// against every output on every clock, plus literal counts per transfer.
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_ce;
  logic        reg_we;
  logic [7:0]  reg_wdata;
  logic [7:0]  bus_rdata;
  logic        cpu_rdy;
  logic        dma_bus_own;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic        dma_wr;
  logic [7:0]  dma_wdata;
  logic        dma_busy;
  logic        put_cycle;

  logic [7:0]  seed;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  // Memory model: every location returns its low address byte xor a seed.
  assign bus_rdata = dma_addr[7:0] ^ seed;

  oam_dma_controller dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_ce     (cpu_ce),
    .reg_we     (reg_we),
    .reg_wdata  (reg_wdata),
    .bus_rdata  (bus_rdata),
    .cpu_rdy    (cpu_rdy),
    .dma_bus_own(dma_bus_own),
    .dma_addr   (dma_addr),
    .dma_rd     (dma_rd),
    .dma_wr     (dma_wr),
    .dma_wdata  (dma_wdata),
    .dma_busy   (dma_busy),
    .put_cycle  (put_cycle)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a transfer is a window of CPU cycles starting at the HALT cycle.
  // Cycle k of the window: 0 = halt, then one optional align cycle (when the
  // halt cycle is a get), then 512 alternating read/write cycles.
  int         m_ce = 0;
  bit         m_active = 1'b0;
  int         m_start = 0;
  bit         m_align = 1'b0;
  logic [7:0] m_page = 8'h00;

  always @(posedge clk) begin
    if (reset) begin
      m_ce     = 0;
      m_active = 1'b0;
    end else if (cpu_ce) begin
      if (m_active && m_ce == m_start + int'(m_align) + 512) begin
        m_active = 1'b0;
      end else if (!m_active && reg_we) begin
        m_active = 1'b1;
        m_start  = m_ce + 1;
        m_page   = reg_wdata;
        m_align  = ((m_ce + 1) % 2 == 0);
      end
      m_ce = m_ce + 1;
    end
  end

  int          k_ph, j_ph, idx_ph;
  logic        e_rdy, e_own, e_busy, e_rd, e_wr, e_put;
  logic [15:0] e_addr;
  logic [7:0]  e_wdata;

  always @(negedge clk) begin
    if (chk_en) begin
      e_rdy = 1'b1; e_own = 1'b0; e_busy = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
      e_addr = 16'h0000; e_wdata = 8'h00;
      e_put = (m_ce % 2 == 1);
      if (m_active) begin
        k_ph   = m_ce - m_start;
        e_rdy  = 1'b0;
        e_busy = 1'b1;
        if (k_ph == 0) begin
          e_own = 1'b0;
        end else if (m_align && k_ph == 1) begin
          e_own  = 1'b1;
          e_addr = 16'h2004;
        end else begin
          j_ph   = k_ph - 1 - int'(m_align);
          idx_ph = j_ph / 2;
          e_own  = 1'b1;
          if (j_ph % 2 == 0) begin
            e_rd   = 1'b1;
            e_addr = {m_page, 8'(idx_ph)};
          end else begin
            e_wr    = 1'b1;
            e_addr  = 16'h2004;
            e_wdata = 8'(idx_ph) ^ seed;
          end
        end
      end
      chk("outputs{rdy,own,busy,rd,wr,put,addr,wdata}",
          {2'b00, cpu_rdy, dma_bus_own, dma_busy, dma_rd, dma_wr, put_cycle, dma_addr, dma_wdata},
          {2'b00, e_rdy, e_own, e_busy, e_rd, e_wr, e_put, e_addr, e_wdata});
    end
  end

  // Per-CPU-cycle tallies used for the literal per-transfer expectations.
  int          stall_cnt = 0, wr_cnt = 0, rd_cnt = 0, align_cnt = 0, rd_on_put = 0;
  int          rd_base = 0;
  logic [15:0] first_rd = 16'h0000, last_rd = 16'h0000;
  logic [7:0]  wr_exp;

  always @(negedge clk) begin
    if (chk_en && cpu_ce && !reset) begin
      if (!cpu_rdy) stall_cnt++;
      if (dma_bus_own && !dma_rd && !dma_wr) align_cnt++;
      if (dma_rd) begin
        if (rd_cnt == rd_base) first_rd = dma_addr;
        last_rd = dma_addr;
        if (put_cycle) rd_on_put++;
        rd_cnt++;
      end
      if (dma_wr) begin
        wr_exp = 8'(wr_cnt - rd_base) ^ seed;
        chk("wr_addr", dma_addr, 16'h2004);
        chk("wr_data_seq", dma_wdata, wr_exp);
        wr_cnt++;
      end
    end
  end

  task automatic tick(input bit ce, input bit we, input logic [7:0] wd);
    cpu_ce    = ce;
    reg_we    = we;
    reg_wdata = wd;
    @(posedge clk);
    #1;
  endtask

  // One CPU cycle; non-ce clocks carry a stray reg_we that must be ignored.
  task automatic ce_step(input int div, input bit we, input logic [7:0] wd);
    repeat (div - 1) tick(1'b0, 1'b1, 8'hEE);
    tick(1'b1, we, wd);
  endtask

  task automatic start_xfer(input logic [7:0] pg, input bit want_put, input int div);
    if (put_cycle != want_put) ce_step(div, 1'b0, 8'h00);
    chk("start_parity", put_cycle, want_put);
    chk("start_idle", dma_busy, 1'b0);
    rd_base = rd_cnt;
    ce_step(div, 1'b1, pg);
  endtask

  task automatic run_xfer(input logic [7:0] pg, input bit want_put, input int div,
                          input int exp_stall, input bit inject);
    int s0, a0, p0, w0;
    s0 = stall_cnt; a0 = align_cnt; p0 = rd_on_put;
    w0 = wr_cnt;
    start_xfer(pg, want_put, div);
    for (int k = 0; k < 700 && dma_busy; k++) ce_step(div, inject && k == 100, 8'h05);
    chk("xfer_done", dma_busy, 1'b0);
    chk("stall_cycles", stall_cnt - s0, exp_stall);
    chk("align_cycles", align_cnt - a0, exp_stall - 513);
    chk("wr_count", wr_cnt - w0, 256);
    chk("rd_count", rd_cnt - rd_base, 256);
    chk("first_rd_addr", first_rd, {pg, 8'h00});
    chk("last_rd_addr", last_rd, {pg, 8'hFF});
    chk("rd_on_put", rd_on_put - p0, 0);
    chk("rdy_after", cpu_rdy, 1'b1);
    rd_base = rd_cnt;
    wr_cnt  = rd_cnt;
  endtask

  initial begin
    cpu_ce = 1'b0; reg_we = 1'b0; reg_wdata = 8'h00; reset = 1'b1; seed = 8'h00;
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'h33);
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("reset_put", put_cycle, 1'b0);
    chk("reset_rdy", cpu_rdy, 1'b1);
    chk("reset_busy", dma_busy, 1'b0);
    chk("reset_addr", dma_addr, 16'h0000);

    for (int i = 0; i < 10; i++) begin
      chk("idle_put", put_cycle, 32'(i % 2));
      chk("idle_own", dma_bus_own, 1'b0);
      tick(1'b1, 1'b0, 8'h00);
    end

    // Write in a get cycle: HALT lands on a put, READ follows directly (513).
    run_xfer(8'h02, 1'b0, 1, 513, 1'b0);
    // Write in a put cycle: HALT lands on a get, one ALIGN cycle (514).
    run_xfer(8'h02, 1'b1, 1, 514, 1'b0);
    seed = 8'h5A;
    // Stray $05 write mid-transfer must not change page or timing.
    run_xfer(8'h02, 1'b0, 1, 513, 1'b1);
    // Top page with sparse cpu_ce, both alignments.
    run_xfer(8'hFF, 1'b1, 3, 514, 1'b0);
    run_xfer(8'hFF, 1'b0, 3, 513, 1'b0);
    // Source page in PPU register space is not filtered.
    run_xfer(8'h20, 1'b0, 1, 513, 1'b0);

    // Reset while the write of idx $40 is on the bus.
    start_xfer(8'h03, 1'b0, 1);
    for (int k = 0; k < 300 && !(dma_wr && wr_cnt - rd_base == 64); k++) ce_step(1, 1'b0, 8'h00);
    chk("reached_idx40_write", {dma_wr, dma_addr}, {1'b1, 16'h2004});
    reset = 1'b1;
    tick(1'b1, 1'b0, 8'h00);
    reset = 1'b0;
    chk("rst_rdy", cpu_rdy, 1'b1);
    chk("rst_wr", dma_wr, 1'b0);
    chk("rst_own", dma_bus_own, 1'b0);
    chk("rst_busy", dma_busy, 1'b0);
    chk("rst_put", put_cycle, 1'b0);
    rd_base = rd_cnt;
    wr_cnt  = rd_cnt;
    run_xfer(8'h03, 1'b0, 1, 513, 1'b0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
